// File: rtl/pdh_capture_writer.sv
// Write-side capture controller: arms, waits for an optional trigger, then writes one
// decimated frame of DEPTH 64-bit PDH samples into the capture BRAM.
module pdh_capture_writer #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = 13,
    parameter int unsigned DEC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_mode_i,
    input  logic             trig_i,
    input  logic [DEC_W-1:0] decim_i,
    input  logic             in_valid_i,
    input  logic [63:0]      in_data_i,
    output logic             bram_we_o,
    output logic [AW-1:0]    bram_waddr_o,
    output logic [63:0]      bram_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [AW:0]      wr_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e           state_q;
    logic [DEC_W-1:0] dec_reload_q;
    logic [DEC_W-1:0] dec_cnt_q;
    logic             trig_q;
    logic [AW-1:0]    addr_q;
    logic [AW:0]      wr_count_q;
    logic             we_q;
    logic [AW-1:0]    waddr_q;
    logic [63:0]      wdata_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            dec_reload_q <= '0;
            dec_cnt_q    <= '0;
            trig_q       <= 1'b0;
            addr_q       <= '0;
            wr_count_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            trig_q <= trig_i;
            we_q   <= 1'b0;
            if (abort_i) begin
                // Abort beats arm and drops any write that would have issued next cycle.
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (arm_i) begin
                            dec_reload_q <= decim_i;
                            dec_cnt_q    <= '0;
                            wr_count_q   <= '0;
                            addr_q       <= '0;
                            done_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= trig_mode_i ? StArmed : StCapture;
                        end else if (state_q == StDone) begin
                            done_q <= 1'b1;
                        end
                    end
                    StArmed: begin
                        if (trig_i && !trig_q) begin
                            state_q <= StCapture;
                        end
                    end
                    StCapture: begin
                        if (in_valid_i) begin
                            if (dec_cnt_q == '0) begin
                                dec_cnt_q  <= dec_reload_q;
                                we_q       <= 1'b1;
                                waddr_q    <= addr_q;
                                wdata_q    <= in_data_i;
                                addr_q     <= addr_q + 1'b1;
                                wr_count_q <= wr_count_q + 1'b1;
                                if (addr_q == LastAddr) begin
                                    state_q <= StDone;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                dec_cnt_q <= dec_cnt_q - 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bram_we_o    = we_q;
    assign bram_waddr_o = waddr_q;
    assign bram_wdata_o = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign wr_count_o   = wr_count_q;

endmodule

// File: tb/tb_pdh_capture_writer.sv
// Directed self-checking bench for pdh_capture_writer: immediate, decimated, triggered,
// abort, re-arm and reset-mid-capture scenarios with hand-derived expectations.
module tb_pdh_capture_writer;

    localparam int DEPTH = 8192;
    localparam int AW    = 13;
    localparam int DEC_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arm;
    logic             abort;
    logic             trig_mode;
    logic             trig_in;
    logic [DEC_W-1:0] decim;
    logic             in_valid;
    logic [63:0]      in_data;
    logic             bram_we;
    logic [AW-1:0]    bram_waddr;
    logic [63:0]      bram_wdata;
    logic             busy;
    logic             done;
    logic [AW:0]      wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pdh_capture_writer #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DEC_W(DEC_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .arm_i       (arm),
        .abort_i     (abort),
        .trig_mode_i (trig_mode),
        .trig_i      (trig_in),
        .decim_i     (decim),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .bram_we_o   (bram_we),
        .bram_waddr_o(bram_waddr),
        .bram_wdata_o(bram_wdata),
        .busy_o      (busy),
        .done_o      (done),
        .wr_count_o  (wr_count)
    );

    function automatic logic [63:0] tag(int i);
        return {32'hDA7A_0000 + 32'(i), 32'(i) ^ 32'h5A5A_5A5A};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drives n consecutive valid samples and expects one write per cycle starting at first.
    task automatic stream(int first, int n, int salt);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = tag(salt + first + k);
            step();
            check("stream_we", 64'(bram_we), 64'd1);
            check("stream_waddr", 64'(bram_waddr), 64'(first + k));
            check("stream_wdata", bram_wdata, tag(salt + first + k));
            check("stream_wr_count", 64'(wr_count), 64'(first + k + 1));
        end
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_we"}, 64'(bram_we), 64'd0);
        check({name, "_waddr"}, 64'(bram_waddr), 64'd0);
        check({name, "_wdata"}, bram_wdata, 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_wr_count"}, 64'(wr_count), 64'd0);
    endtask

    initial begin
        int v;
        int w;
        logic exp_we;

        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 1'b0; trig_in = 1'b0;
        decim = '0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Immediate full frame, decim = 0
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("imm_busy", 64'(busy), 64'd1);
        check("imm_we_idle", 64'(bram_we), 64'd0);
        check("imm_wr_count0", 64'(wr_count), 64'd0);
        stream(0, DEPTH, 0);
        check("imm_done_at_last", 64'(done), 64'd0);
        check("imm_busy_at_last", 64'(busy), 64'd0);
        step();
        check("imm_we_after", 64'(bram_we), 64'd0);
        check("imm_done", 64'(done), 64'd1);
        check("imm_wr_count", 64'(wr_count), 64'(DEPTH));

        // Decimation 1-in-4 armed from DONE
        decim = 16'd3;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("dec_done_cleared", 64'(done), 64'd0);
        check("dec_busy", 64'(busy), 64'd1);
        check("dec_wr_count0", 64'(wr_count), 64'd0);
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1;
            in_data  = tag(1000 + j);
            step();
            if (j % 4 == 0) begin
                check("dec_we", 64'(bram_we), 64'd1);
                check("dec_waddr", 64'(bram_waddr), 64'(j / 4));
                check("dec_wdata", bram_wdata, tag(1000 + j));
            end else begin
                check("dec_we_skip", 64'(bram_we), 64'd0);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("dec_abort_busy", 64'(busy), 64'd0);

        // Decimation with in_valid toggling: counter pauses on invalid cycles
        arm = 1'b1;
        step();
        arm = 1'b0;
        v = 0;
        w = 0;
        for (int j = 0; j < 24; j++) begin
            in_valid = (j % 2 == 0);
            in_data  = tag(2000 + j);
            step();
            exp_we = in_valid && (v % 4 == 0);
            check("tog_we", 64'(bram_we), 64'(exp_we));
            if (exp_we) begin
                check("tog_waddr", 64'(bram_waddr), 64'(w));
                check("tog_wdata", bram_wdata, tag(2000 + j));
                w++;
            end
            if (in_valid) v++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Trigger mode, armed with trig_in already high
        decim = '0;
        trig_mode = 1'b1;
        trig_in = 1'b1;
        in_valid = 1'b0;
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("trg_busy", 64'(busy), 64'd1);
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = tag(2900 + j);
            step();
            check("trg_hold_we", 64'(bram_we), 64'd0);
        end
        trig_in = 1'b0;
        step();
        check("trg_low_we", 64'(bram_we), 64'd0);
        check("trg_low_busy", 64'(busy), 64'd1);
        trig_in = 1'b1;
        in_data = tag(3000);
        step();
        check("trg_edge_we", 64'(bram_we), 64'd0);
        in_data = tag(3001);
        step();
        check("trg_first_we", 64'(bram_we), 64'd1);
        check("trg_first_waddr", 64'(bram_waddr), 64'd0);
        check("trg_first_wdata", bram_wdata, tag(3001));
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Arm and trigger rising in the same cycle must not start capture
        trig_in = 1'b0;
        step();
        arm = 1'b1;
        trig_in = 1'b1;
        step();
        arm = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_data = tag(3100 + j);
            step();
            check("same_cyc_we", 64'(bram_we), 64'd0);
        end
        check("same_cyc_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Abort mid-frame after 100 writes
        trig_mode = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        stream(0, 100, 4000);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = tag(4100);
        step();
        abort = 1'b0;
        check("abort_we", 64'(bram_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);

        // Abort wins over arm
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        check("abort_vs_arm_busy", 64'(busy), 64'd0);
        check("abort_vs_arm_we", 64'(bram_we), 64'd0);

        // Re-arm restarts at address 0; arm during CAPTURE is ignored
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_wr_count0", 64'(wr_count), 64'd0);
        check("rearm_busy", 64'(busy), 64'd1);
        stream(0, 3, 5000);
        arm = 1'b1;
        in_valid = 1'b1;
        in_data = tag(5003);
        step();
        arm = 1'b0;
        check("arm_in_cap_we", 64'(bram_we), 64'd1);
        check("arm_in_cap_waddr", 64'(bram_waddr), 64'd3);
        check("arm_in_cap_wr_count", 64'(wr_count), 64'd4);
        stream(4, DEPTH - 4, 5000);
        step();
        check("rearm_done", 64'(done), 64'd1);
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_data = tag(9000 + j);
            step();
            check("post_done_we", 64'(bram_we), 64'd0);
            check("post_done_wr_count", 64'(wr_count), 64'(DEPTH));
            check("post_done_done", 64'(done), 64'd1);
        end

        // Reset mid-capture, then a complete frame
        arm = 1'b1;
        step();
        arm = 1'b0;
        stream(0, 50, 6000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        arm = 1'b1;
        step();
        arm = 1'b0;
        stream(0, DEPTH, 7000);
        step();
        check("final_done", 64'(done), 64'd1);
        check("final_we", 64'(bram_we), 64'd0);
        check("final_wr_count", 64'(wr_count), 64'(DEPTH));
        check("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
